// File: rtl/button_conditioner.sv
// Six-channel push-button front end: sync, polarity fix, debounce, press pulses and hold counters.
// Optional BTN_AUTOREPEAT_EN adds periodic repeat pulses on the four stat channels.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned TICK_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 25000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_salud,
    input  logic       raw_energia,
    input  logic       raw_hambre,
    input  logic       raw_diversion,
    input  logic       raw_reset,
    input  logic       raw_test,
    output logic       btn_salud,
    output logic       btn_energia,
    output logic       btn_hambre,
    output logic       btn_diversion,
    output logic       btn_reset,
    output logic       btn_test,
    output logic [2:0] count_reset,
    output logic [2:0] count_test
);

    localparam int NCH  = 6;
    localparam int NSTAT = 4;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TK_W = $clog2(TICK_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_CYCLES - 1);
    localparam logic [NCH-1:0]  RELEASED  = ACTIVE_LOW ? {NCH{1'b1}} : {NCH{1'b0}};

    if (DEBOUNCE_CYCLES < 1 || TICK_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("button_conditioner: cycle parameters must be at least 1");
    end

    // Channel order: 0 salud, 1 energia, 2 hambre, 3 diversion, 4 reset, 5 test.
    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1, sync2;
    logic [NCH-1:0]   pressed;
    logic [NCH-1:0]   stable, stable_next;
    logic [DB_W-1:0]  db_cnt      [NCH];
    logic [DB_W-1:0]  db_cnt_next [NCH];
    logic [NSTAT-1:0] stable_d;
    logic [NSTAT-1:0] pulse, pulse_next;
    logic [TK_W-1:0]  tick  [2];
    logic [2:0]       count [2];

    assign raw = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= RELEASED;
            sync2 <= RELEASED;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            stable_next[i] = stable[i];
            db_cnt_next[i] = '0;
            if (pressed[i] != stable[i]) begin
                if (db_cnt[i] == DB_MAX) begin
                    stable_next[i] = ~stable[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RP_W-1:0] REP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt      [NSTAT];
    logic [RP_W-1:0] rep_cnt_next [NSTAT];

    // rep_cnt counts edges since the last pulse; release (stable_next low) kills a due repeat.
    always_comb begin
        for (int i = 0; i < NSTAT; i++) begin
            pulse_next[i]   = stable[i] & ~stable_d[i];
            rep_cnt_next[i] = '0;
            if (stable_next[i] && !pulse_next[i]) begin
                if (rep_cnt[i] == REP_LAST) begin
                    pulse_next[i] = 1'b1;
                end else begin
                    rep_cnt_next[i] = rep_cnt[i] + RP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt <= '{default: '0};
        end else begin
            rep_cnt <= rep_cnt_next;
        end
    end
`else
    assign pulse_next = stable[NSTAT-1:0] & ~stable_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable   <= '0;
            stable_d <= '0;
            pulse    <= '0;
            db_cnt   <= '{default: '0};
        end else begin
            stable   <= stable_next;
            stable_d <= stable[NSTAT-1:0];
            pulse    <= pulse_next;
            db_cnt   <= db_cnt_next;
        end
    end

    // Hold counters clear on stable_next so the count drops on the same edge as the level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick  <= '{default: '0};
            count <= '{default: '0};
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (!stable_next[NSTAT+j]) begin
                    tick[j]  <= '0;
                    count[j] <= '0;
                end else if (stable[NSTAT+j]) begin
                    if (tick[j] == TICK_LAST) begin
                        tick[j] <= '0;
                        if (count[j] != 3'd7) begin
                            count[j] <= count[j] + 3'd1;
                        end
                    end else begin
                        tick[j] <= tick[j] + TK_W'(1);
                    end
                end
            end
        end
    end

    assign btn_salud     = pulse[0];
    assign btn_energia   = pulse[1];
    assign btn_hambre    = pulse[2];
    assign btn_diversion = pulse[3];
    assign btn_reset     = stable[4];
    assign btn_test      = stable[5];
    assign count_reset   = count[0];
    assign count_test    = count[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: two instances (ACTIVE_LOW 0 and 1, inverted stimulus).
// Uses DEBOUNCE_CYCLES=4, TICK_CYCLES=10, REPEAT_CYCLES=8; honours BTN_AUTOREPEAT_EN.
module tb_button_conditioner;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TICK = 10;
    localparam int unsigned REP  = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test;

    wire [3:0] pulse_a, pulse_b;
    wire       lvl_reset_a, lvl_test_a, lvl_reset_b, lvl_test_b;
    wire [2:0] cnt_reset_a, cnt_test_a, cnt_reset_b, cnt_test_b;
    wire [11:0] outs_a = {pulse_a, lvl_reset_a, lvl_test_a, cnt_reset_a, cnt_test_a};
    wire [11:0] outs_b = {pulse_b, lvl_reset_b, lvl_test_b, cnt_reset_b, cnt_test_b};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .raw_salud(raw_salud), .raw_energia(raw_energia), .raw_hambre(raw_hambre),
        .raw_diversion(raw_diversion), .raw_reset(raw_reset), .raw_test(raw_test),
        .btn_salud(pulse_a[0]), .btn_energia(pulse_a[1]), .btn_hambre(pulse_a[2]),
        .btn_diversion(pulse_a[3]), .btn_reset(lvl_reset_a), .btn_test(lvl_test_a),
        .count_reset(cnt_reset_a), .count_test(cnt_test_a)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TICK), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
    ) u_dut_al (
        .clk(clk), .rst_n(rst_n),
        .raw_salud(~raw_salud), .raw_energia(~raw_energia), .raw_hambre(~raw_hambre),
        .raw_diversion(~raw_diversion), .raw_reset(~raw_reset), .raw_test(~raw_test),
        .btn_salud(pulse_b[0]), .btn_energia(pulse_b[1]), .btn_hambre(pulse_b[2]),
        .btn_diversion(pulse_b[3]), .btn_reset(lvl_reset_b), .btn_test(lvl_test_b),
        .count_reset(cnt_reset_b), .count_test(cnt_test_b)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Bit order: {test, reset, diversion, hambre, energia, salud}, 1 = pressed.
    task automatic set_raw(input logic [5:0] v);
        {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud} = v;
    endtask

    task automatic idle(input int cycles);
        set_raw(6'b0);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        int pc_a, pc_b, pe_a, pe_b, pe_e, pe_d, pc_e, pc_d, errs, hambre_seen;
        int exp_c;
        logic exp_l;
        int edges [8];
        int salud_exp;

        // Reset with inputs toggling: all outputs stay low, and on the first edge after.
        rst_n = 1'b0;
        set_raw(6'b0);
        for (int i = 0; i < 3; i++) begin
            set_raw((i % 2 == 0) ? 6'h3f : 6'h15);
            step();
            check("reset_outs_a", 32'(outs_a), 32'd0);
            check("reset_outs_b", 32'(outs_b), 32'd0);
        end
        set_raw(6'b0);
        rst_n = 1'b1;
        step();
        check("post_reset_outs_a", 32'(outs_a), 32'd0);
        check("post_reset_outs_b", 32'(outs_b), 32'd0);
        idle(4);

        // salud held 20 cycles: single pulse after edge 7 (plus one repeat at 15 with autorepeat).
`ifdef BTN_AUTOREPEAT_EN
        salud_exp = 2;
`else
        salud_exp = 1;
`endif
        set_raw(6'b000001);
        pc_a = 0; pc_b = 0; pe_a = -1; pe_b = -1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (pulse_a[0]) begin pc_a++; if (pe_a < 0) pe_a = n; end
            if (pulse_b[0]) begin pc_b++; if (pe_b < 0) pe_b = n; end
        end
        check("salud_pulses_a", 32'(pc_a), 32'(salud_exp));
        check("salud_first_edge_a", 32'(pe_a), 32'd7);
        check("salud_pulses_b", 32'(pc_b), 32'(salud_exp));
        check("salud_first_edge_b", 32'(pe_b), 32'd7);
        set_raw(6'b0);
        pc_a = 0; pc_b = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (n >= 6 && pulse_a[0]) pc_a++;
            if (n >= 6 && pulse_b[0]) pc_b++;
        end
        check("salud_release_a", 32'(pc_a), 32'd0);
        check("salud_release_b", 32'(pc_b), 32'd0);

        // hambre glitch of 3 cycles: never accepted, debounce counter back to 0.
        set_raw(6'b000100);
        hambre_seen = 0;
        for (int n = 0; n < 3; n++) begin
            step();
            if (pulse_a[2] || pulse_b[2]) hambre_seen++;
        end
        set_raw(6'b0);
        for (int n = 0; n < 15; n++) begin
            step();
            if (pulse_a[2] || pulse_b[2]) hambre_seen++;
        end
        check("hambre_glitch_pulses", 32'(hambre_seen), 32'd0);
        check("hambre_db_cnt", 32'(u_dut.db_cnt[2]), 32'd0);

        // raw_reset held 100 cycles: level at edge 6, count n at edge 6+10n, saturating at 7.
        set_raw(6'b010000);
        errs = 0;
        for (int n = 0; n < 100; n++) begin
            step();
            exp_l = (n >= 6);
            exp_c = (n < 6) ? 0 : (((n - 6) / 10 > 7) ? 7 : (n - 6) / 10);
            if (lvl_reset_a !== exp_l || 32'(cnt_reset_a) !== 32'(exp_c) ||
                lvl_reset_b !== exp_l || 32'(cnt_reset_b) !== 32'(exp_c)) errs++;
            if (n == 5)  check("reset_lvl_edge5", 32'(lvl_reset_a), 32'd0);
            if (n == 6)  check("reset_lvl_edge6", 32'(lvl_reset_a), 32'd1);
            if (n == 15) check("reset_cnt_edge15", 32'(cnt_reset_a), 32'd0);
            if (n == 16) check("reset_cnt_edge16", 32'(cnt_reset_a), 32'd1);
            if (n == 75) check("reset_cnt_edge75", 32'(cnt_reset_a), 32'd6);
            if (n == 76) check("reset_cnt_edge76", 32'(cnt_reset_a), 32'd7);
            if (n == 99) check("reset_cnt_sat", 32'(cnt_reset_a), 32'd7);
        end
        check("reset_trace_errs", 32'(errs), 32'd0);
        set_raw(6'b0);
        for (int m = 0; m < 10; m++) begin
            step();
            if (m == 5) begin
                check("reset_rel_lvl_m5", 32'(lvl_reset_a), 32'd1);
                check("reset_rel_cnt_m5", 32'(cnt_reset_a), 32'd7);
            end
            if (m == 6) begin
                check("reset_rel_lvl_m6", 32'(lvl_reset_a), 32'd0);
                check("reset_rel_cnt_m6", 32'(cnt_reset_a), 32'd0);
                check("reset_rel_lvl_b", 32'(lvl_reset_b), 32'd0);
                check("reset_rel_cnt_b", 32'(cnt_reset_b), 32'd0);
            end
        end
        idle(4);

        // energia and diversion pressed together: pulses in the same cycle.
        set_raw(6'b001010);
        pe_e = -1; pe_d = -1; pc_e = 0; pc_d = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (pulse_a[1]) begin pc_e++; if (pe_e < 0) pe_e = n; end
            if (pulse_a[3]) begin pc_d++; if (pe_d < 0) pe_d = n; end
        end
        check("energia_edge", 32'(pe_e), 32'd7);
        check("diversion_edge", 32'(pe_d), 32'd7);
        check("energia_pulses", 32'(pc_e), 32'd1);
        check("diversion_pulses", 32'(pc_d), 32'd1);
        idle(14);

        // raw_test held; one-edge reset at count 3; re-press after 6 edges, counting from 0.
        set_raw(6'b100000);
        for (int n = 0; n < 37; n++) begin
            step();
            if (n == 35) check("test_cnt_edge35", 32'(cnt_test_a), 32'd2);
            if (n == 36) check("test_cnt_edge36", 32'(cnt_test_a), 32'd3);
        end
        rst_n = 1'b0;
        step();
        check("test_rst_cnt_a", 32'(cnt_test_a), 32'd0);
        check("test_rst_lvl_a", 32'(lvl_test_a), 32'd0);
        check("test_rst_cnt_b", 32'(cnt_test_b), 32'd0);
        rst_n = 1'b1;
        for (int m = 0; m < 17; m++) begin
            step();
            if (m == 5) check("test_relvl_m5", 32'(lvl_test_a), 32'd0);
            if (m == 6) begin
                check("test_relvl_m6_a", 32'(lvl_test_a), 32'd1);
                check("test_relvl_m6_b", 32'(lvl_test_b), 32'd1);
            end
            if (m == 15) check("test_recnt_m15", 32'(cnt_test_a), 32'd0);
            if (m == 16) check("test_recnt_m16", 32'(cnt_test_a), 32'd1);
        end
        idle(12);
        check("test_idle_lvl", 32'(lvl_test_a), 32'd0);
        check("test_idle_cnt", 32'(cnt_test_a), 32'd0);

        // salud held 40 cycles: repeat pulses every REP edges only with autorepeat.
        set_raw(6'b000001);
        pc_a = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (pulse_a[0]) begin
                if (pc_a < 8) edges[pc_a] = n;
                pc_a++;
            end
        end
`ifdef BTN_AUTOREPEAT_EN
        check("autorep_pulses", 32'(pc_a), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < pc_a) check("autorep_edge", 32'(edges[k]), 32'(7 + 8 * k));
        end
`else
        check("single_pulses", 32'(pc_a), 32'd1);
        if (pc_a > 0) check("single_edge", 32'(edges[0]), 32'd7);
`endif
        set_raw(6'b0);
        pc_a = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (pulse_a[0]) pc_a++;
        end
        check("autorep_release", 32'(pc_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
